class_bbox_accum: RTL and testbench
===================================

// Module: class_bbox_accum
// PURPOSE
//  Downstream of the pixel classifier. Consumes its 3-bit per-pixel class stream, one pixel/beat in raster order.
//  Per colour class, accumulates over one frame: bounding box (xmin/xmax/ymin/ymax) and pixel count.
//  At end of frame, emits one result record per class on a valid/ready port to the overlay / NIOS reader.
// PARAMETERS
//  IMAGE_W     640  pixels per line (x wraps at IMAGE_W-1)
//  IMAGE_H     480  lines per frame (y saturates at IMAGE_H-1)
//  NUM_CLASSES 6    tracked classes 1..NUM_CLASSES; class 0 = background, classes >NUM_CLASSES ignored
//  MIN_COUNT   16   fewer pixels than this -> record reported with found=0
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous, active-high reset
//  in_valid      in   1   pixel beat valid
//  in_ready      out  1   block can accept a beat
//  in_sop        in   1   first pixel of frame (x=0,y=0); qualified by in_valid&in_ready
//  in_eop        in   1   last pixel of frame
//  in_class      in   3   pixel_classification from classifier
//  res_valid     out  1   result record valid
//  res_ready     in   1   consumer accepts record
//  res_last      out  1   record is for class NUM_CLASSES
//  res_class     out  3   class id of record (1..NUM_CLASSES)
//  res_found     out  1   count >= MIN_COUNT
//  res_xmin/xmax out  11  bbox x bounds; 0 when !found
//  res_ymin/ymax out  10  bbox y bounds; 0 when !found
//  res_count     out  20  pixel count, saturates at 2^20-1
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, res_valid=0, res_last=0, all res_* =0, x=y=0, accumulators cleared.
//  Beat = in_valid & in_ready. States:
//   IDLE:  beats ignored unless in_sop; sop beat clears all accumulators, is processed as (0,0), -> ACCUM.
//   ACCUM: each beat at (x,y): if 1<=in_class<=NUM_CLASSES: count++ (sat), xmin=min, xmax=max, ymin, ymax.
//          First pixel of a class loads xmin=xmax=x, ymin=ymax=y (tracked by per-class seen flag).
//          x++ per beat; x==IMAGE_W-1 -> x=0, y++ (sat at IMAGE_H-1).
//          sop beat in ACCUM: restart frame (clear, process as (0,0)); no results for aborted frame.
//          eop beat: processed, then -> DUMP next cycle; in_ready=0 from the cycle after the eop beat.
//          Short/long frames: eop governs; no check on pixel total.
//   DUMP:  in_ready=0. Index k=1..NUM_CLASSES. res_valid=1 with record k registered (no comb path from acc).
//          Advance k on res_valid&res_ready; res_last=1 when k==NUM_CLASSES; its handshake -> IDLE, in_ready=1.
//          res_* stable while res_valid&!res_ready. res_valid never drops without handshake.
//  Latency: first record valid 2 cycles after eop beat; then 1 record/cycle under res_ready=1.
//  Simultaneous sop&eop on one beat: 1-pixel frame, go to DUMP.
//  Reset mid-ACCUM or mid-DUMP: returns to IDLE, pending records discarded.
//  Widths: x 11b, y 10b, counters 20b; comparisons unsigned.
// STRUCTURE
//  Package vision_pkg: typedef class_t (logic[2:0]), CLASS_BG=3'd0, bbox_rec_t struct (found,xmin,xmax,ymin,ymax,count), state enum.
//  Sub-module class_acc_slot: one class's seen/min/max/count regs with clear+update; instantiated NUM_CLASSES
//  times via generate. Top holds x/y counters, FSM, DUMP mux and output registers.
// TESTING
//  T1 4x4 frame (IMAGE_W=IMAGE_H=4, MIN_COUNT=1), class 2 at (1,1),(2,3) -> rec class2 found=1 x1..2 y1..3 cnt2; others found=0.
//  T2 All pixels class 7 -> 6 records, all found=0, count=0, last only on class 6.
//  T3 res_ready low 5 cycles on record 3 -> res_valid stays 1, fields stable, in_ready=0 throughout DUMP.
//  T4 sop re-asserted mid-frame after class 1 pixels -> earlier class 1 pixels absent from results.
//  T5 single beat sop=eop=1 class 4 -> class4 bbox (0,0,0,0) count1 found=1 (MIN_COUNT=1).
//  T6 rst pulse during DUMP after 2 records -> res_valid=0 next cycle, in_ready=1, new frame accumulates cleanly.

Source files
------------

// File: rtl/vision_pkg.sv
// Shared types and constants for the per-class bounding-box accumulator.
package vision_pkg;

    localparam int unsigned CLASS_W = 3;
    localparam int unsigned X_W     = 11;
    localparam int unsigned Y_W     = 10;
    localparam int unsigned CNT_W   = 20;
    localparam int unsigned ST_W    = 2;

    typedef logic [CLASS_W-1:0] class_t;

    localparam class_t CLASS_BG = 3'd0;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_ACCUM = 2'd1;
    localparam logic [ST_W-1:0] ST_DUMP  = 2'd2;

    typedef struct packed {
        logic             found;
        logic [X_W-1:0]   xmin;
        logic [X_W-1:0]   xmax;
        logic [Y_W-1:0]   ymin;
        logic [Y_W-1:0]   ymax;
        logic [CNT_W-1:0] count;
    } bbox_rec_t;

    // Saturating pixel-count increment.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/class_acc_slot.sv
// One class's bounding box and pixel count; clr+upd together starts a fresh frame with this pixel.
module class_acc_slot
    import vision_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd,
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    output bbox_rec_t        rec
);

    logic             seen_q;
    logic [X_W-1:0]   xmin_q;
    logic [X_W-1:0]   xmax_q;
    logic [Y_W-1:0]   ymin_q;
    logic [Y_W-1:0]   ymax_q;
    logic [CNT_W-1:0] cnt_q;

    // First pixel after a clear loads the box; later pixels widen it.
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q <= 1'b0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymin_q <= '0;
            ymax_q <= '0;
            cnt_q  <= '0;
        end else if (upd) begin
            seen_q <= 1'b1;
            if (clr || !seen_q) begin
                xmin_q <= x;
                xmax_q <= x;
                ymin_q <= y;
                ymax_q <= y;
                cnt_q  <= CNT_W'(1);
            end else begin
                if (x < xmin_q) xmin_q <= x;
                if (x > xmax_q) xmax_q <= x;
                if (y < ymin_q) ymin_q <= y;
                if (y > ymax_q) ymax_q <= y;
                cnt_q <= sat_inc(cnt_q);
            end
        end else if (clr) begin
            seen_q <= 1'b0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymin_q <= '0;
            ymax_q <= '0;
            cnt_q  <= '0;
        end
    end

    always_comb begin
        rec       = '0;
        rec.found = seen_q;
        rec.xmin  = xmin_q;
        rec.xmax  = xmax_q;
        rec.ymin  = ymin_q;
        rec.ymax  = ymax_q;
        rec.count = cnt_q;
    end

endmodule

// File: rtl/class_bbox_accum.sv
// Per-class bounding box / pixel count over a raster frame; one result record per class after end of frame.
module class_bbox_accum
    import vision_pkg::*;
#(
    parameter int unsigned IMAGE_W     = 640,
    parameter int unsigned IMAGE_H     = 480,
    parameter int unsigned NUM_CLASSES = 6,
    parameter int unsigned MIN_COUNT   = 16
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [CLASS_W-1:0] in_class,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_last,
    output logic [CLASS_W-1:0] res_class,
    output logic               res_found,
    output logic [X_W-1:0]     res_xmin,
    output logic [X_W-1:0]     res_xmax,
    output logic [Y_W-1:0]     res_ymin,
    output logic [Y_W-1:0]     res_ymax,
    output logic [CNT_W-1:0]   res_count
);

    logic [ST_W-1:0]    state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [CLASS_W-1:0] k_q, k_d;
    logic               in_ready_d;
    logic               res_valid_d;
    logic               res_last_d;
    logic [CLASS_W-1:0] res_class_d;
    bbox_rec_t          res_q, res_d;

    logic                   beat_c;
    logic                   acc_beat_c;
    logic                   clr_c;
    logic [X_W-1:0]         cx_c;
    logic [Y_W-1:0]         cy_c;
    logic [NUM_CLASSES-1:0] upd_c;
    bbox_rec_t              recs [NUM_CLASSES];
    bbox_rec_t              rec_sel_c;
    bbox_rec_t              rec_out_c;

    assign beat_c     = in_valid && in_ready;
    assign acc_beat_c = beat_c && (in_sop || (state_q == ST_ACCUM));
    assign clr_c      = beat_c && in_sop;
    assign cx_c       = in_sop ? '0 : x_q;
    assign cy_c       = in_sop ? '0 : y_q;

    // Slot g tracks class g+1; background and out-of-range classes match no slot.
    for (genvar g = 0; g < int'(NUM_CLASSES); g++) begin : g_slot
        assign upd_c[g] = acc_beat_c && (in_class != CLASS_BG) && (in_class == CLASS_W'(g + 1));

        class_acc_slot u_slot (
            .clk (clk),
            .rst (rst),
            .clr (clr_c),
            .upd (upd_c[g]),
            .x   (cx_c),
            .y   (cy_c),
            .rec (recs[g])
        );
    end

    // Record for class k_q, bbox zeroed when below the reporting threshold.
    always_comb begin
        rec_sel_c = '0;
        for (int i = 0; i < int'(NUM_CLASSES); i++) begin
            if (k_q == CLASS_W'(i + 1)) rec_sel_c = recs[i];
        end
        rec_out_c       = '0;
        rec_out_c.count = rec_sel_c.count;
        if (rec_sel_c.found && (rec_sel_c.count >= CNT_W'(MIN_COUNT))) begin
            rec_out_c       = rec_sel_c;
            rec_out_c.found = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            k_q       <= CLASS_W'(1);
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            res_class <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            k_q       <= k_d;
            in_ready  <= in_ready_d;
            res_valid <= res_valid_d;
            res_last  <= res_last_d;
            res_class <= res_class_d;
            res_q     <= res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        k_d         = k_q;
        in_ready_d  = in_ready;
        res_valid_d = res_valid;
        res_last_d  = res_last;
        res_class_d = res_class;
        res_d       = res_q;

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (acc_beat_c) begin
                    if (cx_c == X_W'(IMAGE_W - 1)) begin
                        x_d = '0;
                        y_d = (cy_c == Y_W'(IMAGE_H - 1)) ? cy_c : cy_c + Y_W'(1);
                    end else begin
                        x_d = cx_c + X_W'(1);
                        y_d = cy_c;
                    end
                    if (in_eop) begin
                        state_d    = ST_DUMP;
                        in_ready_d = 1'b0;
                        k_d        = CLASS_W'(1);
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_DUMP: begin
                if (res_valid && res_ready && res_last) begin
                    state_d     = ST_IDLE;
                    in_ready_d  = 1'b1;
                    res_valid_d = 1'b0;
                    res_last_d  = 1'b0;
                    res_class_d = '0;
                    res_d       = '0;
                end else if (!res_valid || res_ready) begin
                    // Empty or just handshaken: register the next record.
                    res_valid_d = 1'b1;
                    res_last_d  = (k_q == CLASS_W'(NUM_CLASSES));
                    res_class_d = k_q;
                    res_d       = rec_out_c;
                    k_d         = k_q + CLASS_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                res_valid_d = 1'b0;
                res_last_d  = 1'b0;
            end
        endcase
    end

    assign res_found = res_q.found;
    assign res_xmin  = res_q.xmin;
    assign res_xmax  = res_q.xmax;
    assign res_ymin  = res_q.ymin;
    assign res_ymax  = res_q.ymax;
    assign res_count = res_q.count;

endmodule

// File: tb/tb_class_bbox_accum.sv
// Scoreboard bench for class_bbox_accum on a 4x4 image with MIN_COUNT=1.
module tb_class_bbox_accum;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NC   = 6;
    localparam int MINC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sop;
    logic        in_eop;
    logic [2:0]  in_class;
    logic        res_valid;
    logic        res_ready;
    logic        res_last;
    logic [2:0]  res_class;
    logic        res_found;
    logic [10:0] res_xmin;
    logic [10:0] res_xmax;
    logic [9:0]  res_ymin;
    logic [9:0]  res_ymax;
    logic [19:0] res_count;

    always #5 clk = ~clk;

    class_bbox_accum #(
        .IMAGE_W     (W),
        .IMAGE_H     (H),
        .NUM_CLASSES (NC),
        .MIN_COUNT   (MINC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_class  (in_class),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_last  (res_last),
        .res_class (res_class),
        .res_found (res_found),
        .res_xmin  (res_xmin),
        .res_xmax  (res_xmax),
        .res_ymin  (res_ymin),
        .res_ymax  (res_ymax),
        .res_count (res_count)
    );

    typedef struct {
        int cls;
        bit last;
        bit found;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
        int count;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    bit m_seen [NC+1];
    int m_xmin [NC+1];
    int m_xmax [NC+1];
    int m_ymin [NC+1];
    int m_ymax [NC+1];
    int m_cnt  [NC+1];
    int m_px;
    int m_py;
    bit m_in_frame = 1'b0;

    task automatic model_clear();
        for (int c = 0; c <= NC; c++) begin
            m_seen[c] = 1'b0;
            m_xmin[c] = 0;
            m_xmax[c] = 0;
            m_ymin[c] = 0;
            m_ymax[c] = 0;
            m_cnt[c]  = 0;
        end
    endtask

    task automatic model_pixel(input bit sop, input bit eop, input int cls);
        exp_t e;
        if (sop) begin
            model_clear();
            m_px       = 0;
            m_py       = 0;
            m_in_frame = 1'b1;
        end
        if (!m_in_frame) return;
        if (cls >= 1 && cls <= NC) begin
            if (!m_seen[cls]) begin
                m_seen[cls] = 1'b1;
                m_xmin[cls] = m_px;
                m_xmax[cls] = m_px;
                m_ymin[cls] = m_py;
                m_ymax[cls] = m_py;
            end else begin
                if (m_px < m_xmin[cls]) m_xmin[cls] = m_px;
                if (m_px > m_xmax[cls]) m_xmax[cls] = m_px;
                if (m_py < m_ymin[cls]) m_ymin[cls] = m_py;
                if (m_py > m_ymax[cls]) m_ymax[cls] = m_py;
            end
            m_cnt[cls]++;
        end
        m_px++;
        if (m_px == W) begin
            m_px = 0;
            if (m_py < H - 1) m_py++;
        end
        if (eop) begin
            m_in_frame = 1'b0;
            for (int c = 1; c <= NC; c++) begin
                e.cls   = c;
                e.last  = (c == NC);
                e.found = (m_cnt[c] >= MINC);
                e.xmin  = e.found ? m_xmin[c] : 0;
                e.xmax  = e.found ? m_xmax[c] : 0;
                e.ymin  = e.found ? m_ymin[c] : 0;
                e.ymax  = e.found ? m_ymax[c] : 0;
                e.count = m_cnt[c];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_pixel(input bit sop, input bit eop, input int cls);
        int n;
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_class = 3'(cls);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_pixel: in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        model_pixel(sop, eop, cls);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic collect(input int n, input int stall_idx);
        exp_t        e;
        int          w;
        logic [66:0] snap;
        res_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!res_valid && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            checks++;
            if (!res_valid) begin
                errors++;
                $display("FAIL rec_wait: res_valid=%0b required 1 (record %0d)", res_valid, i);
                return;
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rec_extra: record class %0d present, required none", res_class);
                return;
            end
            e = exp_q.pop_front();
            if (i == stall_idx) begin
                res_ready = 1'b0;
                snap = {res_class, res_last, res_found, res_xmin, res_xmax, res_ymin, res_ymax, res_count};
                repeat (5) begin
                    @(posedge clk); #1;
                    checks++;
                    if (res_valid !== 1'b1 || in_ready !== 1'b0 ||
                        {res_class, res_last, res_found, res_xmin, res_xmax, res_ymin, res_ymax, res_count} !== snap) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%0b in_ready=%0b fields=%h required valid=1 in_ready=0 fields=%h",
                                 res_valid, in_ready,
                                 {res_class, res_last, res_found, res_xmin, res_xmax, res_ymin, res_ymax, res_count}, snap);
                    end
                end
                res_ready = 1'b1;
            end
            checks++;
            if (int'(res_class) !== e.cls || res_last !== e.last || res_found !== e.found ||
                int'(res_xmin) !== e.xmin || int'(res_xmax) !== e.xmax ||
                int'(res_ymin) !== e.ymin || int'(res_ymax) !== e.ymax ||
                int'(res_count) !== e.count || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL record: got cls=%0d last=%0b found=%0b x=%0d..%0d y=%0d..%0d cnt=%0d rdy=%0b required cls=%0d last=%0b found=%0b x=%0d..%0d y=%0d..%0d cnt=%0d rdy=0",
                         res_class, res_last, res_found, res_xmin, res_xmax, res_ymin, res_ymax, res_count, in_ready,
                         e.cls, e.last, e.found, e.xmin, e.xmax, e.ymin, e.ymax, e.count);
            end
            @(posedge clk); #1;
            if (i < n - 1 && !e.last) begin
                checks++;
                if (res_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL back_to_back: res_valid=%0b required 1 after record %0d", res_valid, i);
                end
            end
        end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || res_last !== 1'b0) begin
            errors++;
            $display("FAIL %s: res_valid=%0b in_ready=%0b res_last=%0b required 0 1 0", tag, res_valid, in_ready, res_last);
        end
    endtask

    task automatic send_t1_frame();
        for (int p = 0; p < W * H; p++) begin
            int x;
            int y;
            x = p % W;
            y = p / W;
            send_pixel(p == 0, p == W * H - 1, ((x == 1 && y == 1) || (x == 2 && y == 3)) ? 2 : 0);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        in_class  = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || res_last !== 1'b0 || res_class !== 3'd0 ||
            res_found !== 1'b0 || res_xmin !== 11'd0 || res_xmax !== 11'd0 ||
            res_ymin !== 10'd0 || res_ymax !== 10'd0 || res_count !== 20'd0) begin
            errors++;
            $display("FAIL reset: in_ready=%0b valid=%0b last=%0b cls=%0d cnt=%0d required 1 0 0 0 0",
                     in_ready, res_valid, res_last, res_class, res_count);
        end
    endtask

    task automatic test_basic_bbox();
        send_t1_frame();
        checks++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL eop_latency1: in_ready=%0b res_valid=%0b required 0 0", in_ready, res_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b1 || res_class !== 3'd1) begin
            errors++;
            $display("FAIL eop_latency2: res_valid=%0b res_class=%0d required 1 1", res_valid, res_class);
        end
        collect(NC, -1);
        check_idle("t1_idle");
    endtask

    task automatic test_all_ignored();
        for (int p = 0; p < W * H; p++) send_pixel(p == 0, p == W * H - 1, 7);
        collect(NC, -1);
        check_idle("t2_idle");
    endtask

    task automatic test_stall();
        for (int p = 0; p < W * H; p++) send_pixel(p == 0, p == W * H - 1, int'($urandom_range(0, 7)));
        collect(NC, 2);
        check_idle("t3_idle");
    endtask

    task automatic test_sop_restart();
        send_pixel(1'b1, 1'b0, 1);
        for (int p = 1; p < 6; p++) send_pixel(1'b0, 1'b0, 1);
        for (int p = 0; p < W * H; p++) send_pixel(p == 0, p == W * H - 1, (p % 3 == 0) ? 3 : 5);
        collect(NC, -1);
        check_idle("t4_idle");
    endtask

    task automatic test_single_beat();
        send_pixel(1'b0, 1'b1, 5);
        repeat (3) @(posedge clk);
        #1;
        check_idle("idle_ignore");
        send_pixel(1'b1, 1'b1, 4);
        collect(NC, -1);
        check_idle("t5_idle");
    endtask

    task automatic test_long_frame();
        for (int p = 0; p < 24; p++) send_pixel(p == 0, p == 23, (p >= 16) ? 3 : ((p == 5) ? 6 : 0));
        collect(NC, -1);
        check_idle("long_idle");
    endtask

    task automatic test_reset_in_dump();
        for (int p = 0; p < W * H; p++) send_pixel(p == 0, p == W * H - 1, int'($urandom_range(0, 6)));
        collect(2, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("t6_reset");
        exp_q.delete();
        send_t1_frame();
        collect(NC, -1);
        check_idle("t6_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_bbox();
        test_all_ignored();
        test_stall();
        test_sop_restart();
        test_single_beat();
        test_long_frame();
        test_reset_in_dump();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected records never produced, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
